alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin arbitration on ties, and one operation in flight at a time.
// A grant latches the winner's operands onto the ALU drive registers (EXEC).
// The ALU result is captured one cycle later (DONE).
module alu_share_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic        right0,
    input  logic        right1,
    input  logic        sign0,
    input  logic        sign1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res_out,
    output logic        zero_out,
    output logic        ovf_out,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_right,
    output logic        alu_sign,
    input  logic [31:0] alu_res,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    // last_grant starts at the other requester so RR_INIT wins the first tie
    localparam logic LastInit = (RR_INIT == 0) ? 1'b1 : 1'b0;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   any_req;
    logic   grant1;
    logic   ovf;

    // Arbitration: a lone requester wins; on a tie, the one not granted last wins
    always_comb begin
        any_req = req0 | req1;
        grant1  = req1 & (~req0 | ~last_grant);
    end

    // Signed overflow of ADD/SUB, judged from the operands held on the ALU drive
    always_comb begin
        ovf = 1'b0;
        if (alu_sign) begin
            case (alu_op)
                3'b010:  ovf = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
                3'b110:  ovf = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
                default: ovf = 1'b0;
            endcase
        end
    end

    // Control FSM with registered handshake pulses, ALU drive and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            owner      <= 1'b0;
            last_grant <= LastInit;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            res_out    <= 32'd0;
            zero_out   <= 1'b0;
            ovf_out    <= 1'b0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_op     <= 3'b000;
            alu_right  <= 1'b0;
            alu_sign   <= 1'b0;
        end else begin
            // Pulses are high for exactly one cycle
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (any_req) begin
                        state     <= StExec;
                        owner     <= grant1;
                        ack0      <= ~grant1;
                        ack1      <= grant1;
                        if (req0 && req1) begin
                            last_grant <= grant1;
                        end
                        alu_a     <= grant1 ? a1 : a0;
                        alu_b     <= grant1 ? b1 : b0;
                        alu_op    <= grant1 ? op1 : op0;
                        alu_right <= grant1 ? right1 : right0;
                        alu_sign  <= grant1 ? sign1 : sign0;
                    end
                end
                StExec: begin
                    state    <= StDone;
                    res_out  <= alu_res;
                    zero_out <= alu_zero;
                    ovf_out  <= ovf;
                    done0    <= ~owner;
                    done1    <= owner;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter.
// The shared ALU is modelled here as plain arithmetic.
// Expected grants, results and overflow come from a transaction-level model.
module tb_alu_share_arbiter;

    localparam int unsigned RR_INIT = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic        right0 = 1'b0, right1 = 1'b0, sign0 = 1'b0, sign1 = 1'b0;
    logic        ack0, ack1, done0, done1;
    logic [31:0] res_out;
    logic        zero_out, ovf_out;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_right, alu_sign;
    logic [31:0] alu_res;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;

    // Transaction model: pending requests, their operands, last tie winner
    bit          pend [2];
    logic [31:0] ma [2];
    logic [31:0] mb [2];
    logic [2:0]  mop [2];
    logic        mright [2];
    logic        msign [2];
    int          m_last;

    alu_share_arbiter #(.RR_INIT(RR_INIT)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .right0(right0), .right1(right1), .sign0(sign0), .sign1(sign1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res_out(res_out), .zero_out(zero_out), .ovf_out(ovf_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_right(alu_right), .alu_sign(alu_sign),
        .alu_res(alu_res), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic right);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a | b);
            3'b101:  return right ? (b >> a[4:0]) : (b << a[4:0]);
            3'b110:  return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Overflow judged by whether the exact signed result fits in 32 bits
    function automatic logic ovf_fn(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op, input logic sign);
        longint s;
        if (!sign) return 1'b0;
        if (op == 3'b010) s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 3'b110) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Shared ALU
    assign alu_res  = alu_fn(alu_a, alu_b, alu_op, alu_right);
    assign alu_zero = (alu_res == 32'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic right, input logic sign);
        pend[r] = 1'b1;
        ma[r] = a; mb[r] = b; mop[r] = op; mright[r] = right; msign[r] = sign;
        if (r == 0) begin
            req0 = 1'b1; a0 = a; b0 = b; op0 = op; right0 = right; sign0 = sign;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; op1 = op; right1 = right; sign1 = sign;
        end
    endtask

    task automatic rand_req(input int r);
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_req(r, a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    endtask

    // Async reset, checked before any clock edge, released between edges
    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_res", res_out, 32'd0);
        chk("rst_flags", {30'd0, zero_out, ovf_out}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctl", {27'd0, alu_op, alu_right, alu_sign}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_last = (RR_INIT == 0) ? 1 : 0;
    endtask

    // Called #1 after an edge with the DUT idle at the next edge; serves one operation
    task automatic serve(input bit raise_other, output int w);
        logic [31:0] er;
        logic        ev;
        if (pend[0] && pend[1]) begin
            w = (m_last == 0) ? 1 : 0;
            m_last = w;
        end else if (pend[0]) begin
            w = 0;
        end else begin
            w = 1;
        end
        er = alu_fn(ma[w], mb[w], mop[w], mright[w]);
        ev = ovf_fn(ma[w], mb[w], mop[w], msign[w]);
        @(posedge clk); #1;
        chk("ack0", 32'(ack0), 32'(w == 0));
        chk("ack1", 32'(ack1), 32'(w == 1));
        chk("alu_a", alu_a, ma[w]);
        chk("alu_b", alu_b, mb[w]);
        chk("alu_ctl", {27'd0, alu_op, alu_right, alu_sign}, {27'd0, mop[w], mright[w], msign[w]});
        // Winner drops req and scrambles operands; the in-flight op must not notice
        pend[w] = 1'b0;
        if (w == 0) begin req0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 3'($urandom); end
        else        begin req1 = 1'b0; a1 = $urandom; b1 = $urandom; op1 = 3'($urandom); end
        if (raise_other && !pend[1 - w]) rand_req(1 - w);
        @(posedge clk); #1;
        chk("done0", 32'(done0), 32'(w == 0));
        chk("done1", 32'(done1), 32'(w == 1));
        chk("ack_exec", {30'd0, ack1, ack0}, 32'd0);
        chk("res_out", res_out, er);
        chk("zero_out", 32'(zero_out), 32'(er == 32'd0));
        chk("ovf_out", 32'(ovf_out), 32'(ev));
        @(posedge clk); #1;
        chk("done_off", {30'd0, done1, done0}, 32'd0);
        chk("res_hold", res_out, er);
    endtask

    initial begin
        int w;
        #1;
        do_reset();

        // Lone ADD accepted at the first edge after reset release
        set_req(0, 32'd5, 32'd7, 3'b010, 1'b0, 1'b0);
        serve(1'b0, w);
        chk("add_res", res_out, 32'd12);
        chk("add_flags", {30'd0, zero_out, ovf_out}, 32'd0);

        // Request dropped before any edge sees it: no ack
        req1 = 1'b1;
        #3 req1 = 1'b0;
        @(posedge clk); #1;
        chk("drop_ack", {30'd0, ack1, ack0}, 32'd0);

        // SUB overflow with and without sign enable
        set_req(1, 32'h8000_0000, 32'd1, 3'b110, 1'b0, 1'b1);
        serve(1'b0, w);
        chk("sub_res", res_out, 32'h7FFF_FFFF);
        chk("sub_ovf", 32'(ovf_out), 32'd1);
        set_req(1, 32'h8000_0000, 32'd1, 3'b110, 1'b0, 1'b0);
        serve(1'b0, w);
        chk("sub_noovf", 32'(ovf_out), 32'd0);

        // Right shift and signed less-than
        set_req(0, 32'd4, 32'hF0, 3'b101, 1'b1, 1'b0);
        serve(1'b0, w);
        chk("shr_res", res_out, 32'h0000_000F);
        set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b0, 1'b0);
        serve(1'b0, w);
        chk("slt_res", res_out, 32'd1);

        // Reset during EXEC aborts the operation: no done afterwards
        set_req(0, 32'd9, 32'd3, 3'b010, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("abort_ack0", 32'(ack0), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("abort_nodone", {30'd0, done1, done0}, 32'd0);
            @(posedge clk); #1;
        end
        set_req(1, 32'd20, 32'd22, 3'b010, 1'b0, 1'b0);
        serve(1'b0, w);
        chk("post_rst_res", res_out, 32'd42);

        // Both requesting from reset, each re-raising after service: 0,1,0,1
        do_reset();
        rand_req(0);
        rand_req(1);
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, w);
            chk("rr_order", 32'(w), 32'(i % 2));
            rand_req(w);
        end
        while (pend[0] || pend[1]) serve(1'b0, w);

        // req1 raised during requester 0's EXEC; one idle cycle then ack1
        set_req(0, 32'd1, 32'd2, 3'b001, 1'b0, 1'b0);
        serve(1'b1, w);
        serve(1'b0, w);
        chk("late_req_winner", 32'(w), 32'd1);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) rand_req(r);
            end
            if (!pend[0] && !pend[1]) begin
                @(posedge clk); #1;
                chk("idle_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                serve(1'($urandom_range(0, 1)), w);
            end
        end
        while (pend[0] || pend[1]) serve(1'b0, w);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
